fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the single-cycle controller/datapath.
- Owns the program counter and issues word-aligned requests to instruction memory over a valid/ready handshake.
- Registers the returned word and presents it as Instr[31:0] with instr_valid.
- Advances on a consume strobe, selecting PC+4 or the branch target from the PCSrc/Result pair produced downstream.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to imem,
// and holds the returned word until downstream consumes it. Optional macro: FETCH_PERF_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] Result,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       Instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus8,
  output logic [1:0]        dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  // Handshake: a request transfers on any rising edge where imem_req & imem_ready;
  // imem_req and imem_addr stay stable until that happens (no retraction).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] C_INC4  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] C_INC8  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] C_ALIGN = ~ADDR_W'(3);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              w_accept;
  logic              w_advance;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_accept  = (r_state == S_REQ) && imem_ready;
  assign w_advance = (r_state == S_HOLD) && !stall;
  // Branch target is forced word-aligned by masking the low two bits.
  assign w_pc_next = PCSrc ? (Result & C_ALIGN) : (r_pc + C_INC4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_REQ;
      S_REQ:   if (w_accept)  w_next_state = S_HOLD;
      S_HOLD:  if (w_advance) w_next_state = S_REQ;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      S_REQ:   imem_req    = 1'b1;
      S_HOLD:  instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      if (w_accept)  r_instr <= imem_rdata;
      if (w_advance) r_pc    <= w_pc_next;
    end
  end

  assign imem_addr = r_pc;
  assign PC        = r_pc;
  assign PCPlus8   = r_pc + C_INC8;
  assign Instr     = r_instr;
  assign dbg_state = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_accept) r_fetch_count <= r_fetch_count + 32'd1;
      if ((r_state == S_HOLD) && stall) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetch/branch/stall/reset scenarios with a
// scoreboard of expected {PC, Instr, PCPlus8} checked whenever a new Instr appears.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] Result = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int total = 0;
  int bad = 0;
  logic [95:0] exp_q[$];
  logic [31:0] model_pc;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .Result(Result), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .Instr(Instr), .instr_valid(instr_valid),
    .PC(PC), .PCPlus8(PCPlus8), .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  // clock / memory model
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    logic [31:0] p8;
    p8 = pc + 32'd8;
    exp_q.push_back({pc, mem_word(pc), p8});
  endtask

  // monitor: each fresh Instr is compared against the head of the queue
  initial begin
    logic        prev_valid;
    logic [95:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_valid = 1'b0;
      end else begin
        if (instr_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr", Instr, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", PC, e[95:64]);
            chk("sb_instr", Instr, e[63:32]);
            chk("sb_pcplus8", PCPlus8, e[31:0]);
          end
        end
        prev_valid = instr_valid;
      end
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid_seen"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic advance(input logic branch, input logic [31:0] target);
    stall  = 1'b0;
    PCSrc  = branch;
    Result = target;
    @(posedge clk);
    #1;
    model_pc = branch ? {target[31:2], 2'b00} : model_pc + 32'd4;
    push_exp(model_pc);
    PCSrc  = 1'($urandom_range(0, 1));
    Result = $urandom;
    @(negedge clk);
    chk("req_high", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, model_pc);
  endtask

  task automatic do_reset_release();
    reset = 1'b1;
    model_pc = 32'h0;
    push_exp(model_pc);
    #1;
    chk("idle_req_low", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    // reset values
    #3;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_pcplus8", PCPlus8, 32'h8);
    repeat (2) @(negedge clk);

    // straight-line fetch 0,4,8,12 with ready tied high
    do_reset_release();
    @(negedge clk);
    chk("latency2_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_req_low", {31'd0, imem_req}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      advance(1'b0, $urandom);
      @(negedge clk);
      chk("seq_pc", PC, 32'(k * 4));
    end

    // ready low for 3 cycles at PC=0x10
    imem_ready = 1'b0;
    advance(1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      PCSrc = 1'b1;
      Result = $urandom;
      @(negedge clk);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("ready_load_instr", Instr, 32'hC0CE_0010);

    // branch to 0x103 held off by 4 stall cycles; ready toggling is ignored in HOLD
    for (int k = 0; k < 4; k++) begin
      stall = 1'b1;
      PCSrc = 1'b1;
      Result = 32'h103;
      imem_ready = 1'(k % 2);
      @(negedge clk);
      chk("stall_pc", PC, 32'h10);
      chk("stall_instr", Instr, 32'hC0CE_0010);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b1;
    advance(1'b1, 32'h103);
    chk("branch_addr", imem_addr, 32'h100);
    wait_valid("branch");

    // wrap at top of address space
    advance(1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("top_pcplus8", PCPlus8, 32'h4);
    advance(1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    wait_valid("wrap");

    // reset in REQ with ready low
    imem_ready = 1'b0;
    advance(1'b0, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midreq_req_drop", {31'd0, imem_req}, 32'd0);
    chk("midreq_pc", PC, 32'h0);
    chk("midreq_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    imem_ready = 1'b1;
    do_reset_release();
    wait_valid("after_reset");
    advance(1'b0, 32'h0);
    wait_valid("after_reset2");

`ifdef FETCH_PERF_EN
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    do_reset_release();
    wait_valid("perf1");
    stall = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      advance(1'b0, 32'h0);
      wait_valid("perf_n");
    end
    chk("fetch_count", fetch_count, 32'd5);
    chk("stall_count", stall_count, 32'd3);
    reset = 1'b0;
    #1;
    chk("fetch_count_rst", fetch_count, 32'd0);
    chk("stall_count_rst", stall_count, 32'd0);
`endif

    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    do_reset_release();
    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
